// File: rtl/scan_master.sv
// Scan-chain test controller: loads a pattern, runs functional capture cycles,
// unloads the chain and reports a masked compare of the unloaded vector.
module scan_master #(
   parameter int   CHAIN_LEN = 16,
   parameter int   CAP_W     = 4,
   parameter logic FILL      = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [CHAIN_LEN-1:0] i_pattern,
   input  logic [CHAIN_LEN-1:0] i_expect,
   input  logic [CHAIN_LEN-1:0] i_mask,
   input  logic [CAP_W-1:0]     i_capture_cycles,
   output logic                 o_scan_en,
   output logic                 o_scan_in,
   input  logic                 i_scan_out,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CHAIN_LEN-1:0] o_captured,
   output logic                 o_pass
);

   localparam int SW = $clog2(CHAIN_LEN + 1);
   localparam logic [SW-1:0] LAST = SW'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT_IN, S_CAPTURE, S_SHIFT_OUT, S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [CHAIN_LEN-1:0] r_pat_sr;
   logic [CHAIN_LEN-1:0] r_expect;
   logic [CHAIN_LEN-1:0] r_mask;
   logic [CAP_W-1:0]     r_cap_cycles;
   logic [CAP_W-1:0]     r_cap_cnt;
   logic [SW-1:0]        r_shift_cnt;
   logic [CHAIN_LEN-1:0] r_captured;
   logic                 r_pass;
   logic                 r_scan_en;
   logic                 r_scan_in;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_shift_last;
   logic [CHAIN_LEN-1:0] w_cap_shift;
   logic                 w_pass_next;
   logic                 w_scan_en_next;
   logic                 w_scan_in_next;
   logic                 w_busy_next;
   logic                 w_done_next;

   assign w_shift_last = (r_shift_cnt == LAST);
   // Unload fills from the top so the first tail bit ends up in bit 0.
   assign w_cap_shift  = {i_scan_out, r_captured[CHAIN_LEN-1:1]};
   assign w_pass_next  = &((w_cap_shift ~^ r_expect) | ~r_mask);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      if (i_start) w_state_next = S_SHIFT_IN;
         S_SHIFT_IN:  if (w_shift_last)
                         w_state_next = (r_cap_cycles == '0) ? S_SHIFT_OUT : S_CAPTURE;
         S_CAPTURE:   if (r_cap_cnt == CAP_W'(1)) w_state_next = S_SHIFT_OUT;
         S_SHIFT_OUT: if (w_shift_last) w_state_next = S_DONE;
         S_DONE:      w_state_next = S_IDLE;
         default:     w_state_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so each
   // output is valid for the whole cycle the FSM spends in that state.
   always_comb begin
      w_scan_en_next = (w_state_next == S_SHIFT_IN) || (w_state_next == S_SHIFT_OUT);
      w_busy_next    = (w_state_next == S_SHIFT_IN) || (w_state_next == S_CAPTURE) ||
                       (w_state_next == S_SHIFT_OUT);
      w_done_next    = (w_state_next == S_DONE);
      w_scan_in_next = 1'b0;
      if (w_state_next == S_SHIFT_IN)
         w_scan_in_next = (r_state == S_IDLE) ? i_pattern[0] : r_pat_sr[0];
      else if (w_state_next == S_SHIFT_OUT)
         w_scan_in_next = FILL;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_scan_en    <= 1'b0;
         r_scan_in    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pat_sr     <= '0;
         r_expect     <= '0;
         r_mask       <= '0;
         r_cap_cycles <= '0;
         r_cap_cnt    <= '0;
         r_shift_cnt  <= '0;
         r_captured   <= '0;
         r_pass       <= 1'b0;
      end else begin
         r_scan_en <= w_scan_en_next;
         r_scan_in <= w_scan_in_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         case (r_state)
            S_IDLE: if (i_start) begin
               // Bit 0 goes out immediately; the rest wait in the shifter.
               r_pat_sr     <= i_pattern >> 1;
               r_expect     <= i_expect;
               r_mask       <= i_mask;
               r_cap_cycles <= i_capture_cycles;
               r_captured   <= '0;
               r_pass       <= 1'b0;
               r_shift_cnt  <= '0;
            end
            S_SHIFT_IN: begin
               r_pat_sr <= r_pat_sr >> 1;
               if (w_shift_last) begin
                  r_shift_cnt <= '0;
                  r_cap_cnt   <= r_cap_cycles;
               end else begin
                  r_shift_cnt <= r_shift_cnt + SW'(1);
               end
            end
            S_CAPTURE: r_cap_cnt <= r_cap_cnt - CAP_W'(1);
            S_SHIFT_OUT: begin
               r_captured <= w_cap_shift;
               if (w_shift_last) begin
                  r_shift_cnt <= '0;
                  r_pass      <= w_pass_next;
               end else begin
                  r_shift_cnt <= r_shift_cnt + SW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_scan_en  = r_scan_en;
   assign o_scan_in  = r_scan_in;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_captured = r_captured;
   assign o_pass     = r_pass;

endmodule

// File: tb/tb_scan_master.sv
// Bench for scan_master: an 8-flop chain model on the DUT's scan port and a
// cycle-range reference for the expected control waveform and unload result.
module tb_scan_master;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] pattern = '0;
   logic [N-1:0] expect_v = '0;
   logic [N-1:0] mask = '0;
   logic [3:0]   capture_cycles = '0;
   logic         scan_en, scan_in, scan_out, busy, done, pass;
   logic [N-1:0] captured;

   logic [N-1:0] chain = '0;
   logic [N-1:0] func_val = '0;

   int checks = 0;
   int failures = 0;

   scan_master #(.CHAIN_LEN(N), .CAP_W(4), .FILL(1'b0)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_pattern(pattern), .i_expect(expect_v), .i_mask(mask),
      .i_capture_cycles(capture_cycles),
      .o_scan_en(scan_en), .o_scan_in(scan_in), .i_scan_out(scan_out),
      .o_busy(busy), .o_done(done), .o_captured(captured), .o_pass(pass)
   );

   always #5 clk = ~clk;

   // Chain: bit N-1 is the head, bit 0 the tail; functional mode loads func_val.
   assign scan_out = chain[0];
   always @(posedge clk) begin
      if (scan_en) chain <= {scan_in, chain[N-1:1]};
      else         chain <= func_val;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Runs one test from IDLE; extra start pulses are raised in cycles sa/sb.
   task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] expv,
                           input logic [N-1:0] msk, input logic [3:0] c,
                           input logic [N-1:0] fval, input int sa, input int sb);
      logic [N-1:0] cap_exp;
      logic         pass_exp;
      int           last;
      logic [3:0]   ctl_exp;
      cap_exp  = (c == 0) ? pat : fval;
      pass_exp = (((cap_exp ^ expv) & msk) == '0);
      last     = 2 * N + int'(c) + 1;
      func_val = fval;
      pattern = pat; expect_v = expv; mask = msk; capture_cycles = c;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= last; cyc++) begin
         ctl_exp[3] = (cyc <= N) || (cyc > N + int'(c) && cyc < last);
         ctl_exp[2] = (cyc <= N) ? pat[cyc-1] : 1'b0;
         ctl_exp[1] = (cyc < last);
         ctl_exp[0] = (cyc == last);
         chk($sformatf("ctl c=%0d cyc=%0d", c, cyc),
             {28'd0, scan_en, scan_in, busy, done}, {28'd0, ctl_exp});
         if (cyc == last) begin
            chk("captured", {24'd0, captured}, {24'd0, cap_exp});
            chk("pass", {31'd0, pass}, {31'd0, pass_exp});
         end
         if (cyc == sa || cyc == sb) start = 1'b1;
         if (cyc < last) begin
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("idle_after", {29'd0, busy, done, scan_en}, 32'd0);
      chk("hold_cap", {23'd0, pass, captured}, {23'd0, pass_exp, cap_exp});
      $display("test pat=%02h exp=%02h mask=%02h C=%0d fval=%02h captured=%02h pass=%0d",
               pat, expv, msk, c, fval, captured, pass);
   endtask

   initial begin
      logic [N-1:0] p, f, m, e;
      logic [3:0]   c;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset", {22'd0, scan_en, scan_in, busy, done, pass, captured} & 32'h1FFF, 32'd0);

      run_test(8'hA5, 8'hA5, 8'hFF, 4'd0, 8'h00, 0, 0);
      run_test(8'h00, 8'h3C, 8'hFF, 4'd2, 8'h3C, 0, 0);
      run_test(8'hA5, 8'hF5, 8'h0F, 4'd0, 8'h00, 0, 0);
      run_test(8'hA5, 8'hF5, 8'hFF, 4'd0, 8'h00, 0, 0);
      run_test(8'h5A, 8'h5A, 8'hFF, 4'd0, 8'h00, 3, 17);
      run_test(8'hC3, 8'h00, 8'h00, 4'd0, 8'h00, 0, 0);

      // Reset asserted during shift-in cycle 5.
      pattern = 8'h96; capture_cycles = 4'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_reset", {22'd0, scan_en, scan_in, busy, done, pass, captured} & 32'h1FFF, 32'd0);
      $display("test mid-shift reset scan_en=%0d busy=%0d", scan_en, busy);
      run_test(8'h96, 8'h96, 8'hFF, 4'd0, 8'h00, 0, 0);

      run_test(8'h11, 8'h7E, 8'hFF, 4'd15, 8'h7E, 0, 0);

      for (int t = 0; t < 20; t++) begin
         p = N'($urandom);
         f = N'($urandom);
         m = N'($urandom);
         c = 4'($urandom_range(0, 15));
         e = ($urandom_range(0, 1) == 1) ? ((c == 0) ? p : f) : N'($urandom);
         run_test(p, e, m, c, f, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scan_master.md
Name: scan_master

Overview:
- Scan-chain controller. It drives the DPLL's DFT port group (scan_en_top / scan_in_top) and collects scan_out_top, sitting at the opposite end of the chain from the PFD→LPF→N_divide→lock-flop chain.
- Each test runs three phases: shift a CHAIN_LEN-bit pattern into the chain, release scan_en for a programmable number of functional capture cycles, then shift the chain contents out.
- The unloaded vector is compared against an expected value under a mask, producing a pass/fail flag.
- Used by bring-up firmware and the FPGA validation harness. clk must be the same clock that drives the chain flops (pll_clk in DPLL_top).

Parameters:
- CHAIN_LEN, 16, number of flops in the target chain (≥2).
- CAP_W, 4, width of capture_cycles.
- FILL, 1'b0, value driven on scan_in during the shift-out phase.

Ports:
- clk  in  1  chain clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a test; sampled only in IDLE.
- pattern  in  CHAIN_LEN  load vector; latched on accepted start.
- expect  in  CHAIN_LEN  expected unload vector; latched on accepted start.
- mask  in  CHAIN_LEN  compare mask, 1 = compare this bit; latched on accepted start.
- capture_cycles  in  CAP_W  functional cycles between load and unload; latched on accepted start.
- scan_en  out  1  to chain scan_en.
- scan_in  out  1  to chain head.
- scan_out  in  1  from chain tail.
- busy  out  1  test in progress.
- done  out  1  one-cycle completion pulse.
- captured  out  CHAIN_LEN  unloaded vector.
- pass  out  1  masked compare result.

Behaviour:
- Reset: on any posedge with rst=1, go to IDLE and clear all outputs (scan_en, scan_in, busy, done, captured, pass = 0) plus all counters and latches. Reset wins over everything, including mid-shift. The chain contents are left undefined.
- Output timing: scan_en, scan_in, busy and done are registered. Nothing combinational runs from input to output.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - start=1 at edge 0 latches pattern, expect, mask and capture_cycles, clears captured/pass, and enters SHIFT_IN.
  - start is ignored in every other state.
- SHIFT_IN (cycles 1..N, N = CHAIN_LEN):
  - scan_en=1; scan_in = pattern[i] in shift cycle i (i = 0..N-1, LSB first).
  - After N cycles, chain flop nearest scan_out holds pattern[0].
- CAPTURE (cycles N+1..N+C, C = latched capture_cycles):
  - scan_en=0, scan_in=0; the chain runs functionally.
  - C=0 skips this state entirely: SHIFT_IN goes straight to SHIFT_OUT with no scan_en gap.
- SHIFT_OUT (cycles N+C+1..2N+C):
  - scan_en=1, scan_in=FILL.
  - At the closing edge of shift-out cycle j, sample scan_out (the pre-edge tail value) into captured[j].
- DONE (cycle 2N+C+1):
  - done=1 for exactly one cycle, busy=0, scan_en=0.
  - pass = &((captured ~^ expect) | ~mask), all N bits included.
  - Next state is IDLE.
- busy: 1 in cycles 1..2N+C, 0 otherwise.
- Hold: captured and pass keep their values until the next accepted start or reset.
- start asserted during DONE is ignored. start in the first IDLE cycle after DONE is accepted.
- Loopback identity: with C=0 and an ideal N-flop shift chain, captured == pattern.
- Counters: a shift counter of width $clog2(CHAIN_LEN+1) and a CAP_W capture counter. Both terminate exactly, with no wrap. C = 2^CAP_W−1 must work.
- mask=0 gives pass=1 regardless of captured.

Test Plan:
- Loopback, N=8, C=0: 8-flop chain model, pattern=8'hA5, expect=8'hA5, mask=8'hFF → scan_en high cycles 1–16; done at cycle 17; captured=8'hA5; pass=1.
- Capture, N=8, C=2: chain model parallel-loads 8'h3C when scan_en=0; pattern=8'h00, expect=8'h3C → scan_en low in exactly cycles 9–10; done at cycle 19; captured=8'h3C; pass=1.
- Masked compare: loopback, pattern=8'hA5, expect=8'hF5, mask=8'h0F → pass=1. Same run with mask=8'hFF → pass=0; captured=8'hA5 in both.
- start pulsed at cycles 3 and 17 of a C=0, N=8 run → only one test runs; a start at cycle 18 (first IDLE) begins a new test.
- rst=1 at cycle 5 of SHIFT_IN → next cycle scan_en=0, busy=0, done=0, captured=0; a subsequent start runs a full correct test.
- C=15 (CAP_W=4), N=8: scan_en low for exactly 15 cycles; done at cycle 32.
